stack_cpu_ctrl_v2: RTL and testbench
====================================

Name: stack_cpu_ctrl_v2

Overview:
Parametrised multicycle controller for the 3-bit-opcode stack machine. It adds four things the first-generation controller lacks:
- a memory ready handshake with wait states;
- an internal stack-depth tracker with overflow and underflow detection;
- a memory timeout watchdog;
- a sticky FAULT state.

It sits between the instruction register and the datapath (PC, IR, MDR, A/B registers, ALU, hardware stack, memory), and it drives every datapath strobe.

Parameters:
- STACK_DEPTH, 8, capacity of the hardware stack in entries (>=2).
- DEPTH_W, $clog2(STACK_DEPTH+1), width of the depth counter. Derived; do not override.
- WAIT_TIMEOUT, 15, number of consecutive not-ready cycles in a memory wait state before a timeout fault (>=1).
- TMR_W, $clog2(WAIT_TIMEOUT+1), width of the timeout counter. Derived.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- opcode  in  3  IR[7:5]: 000 ADD, 001 SUB, 010 AND, 011 NOT, 100 PUSH, 101 POP, 110 JMP, 111 JZ.
- tos_zero  in  1  top-of-stack == 0, from the stack.
- mem_ready  in  1  memory has completed the current access.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- addr_src  out  1  0 = PC, 1 = IR address field.
- ir_write  out  1  load IR.
- pc_write  out  1  load PC.
- jump  out  1  PC source select: 0 = PC+1, 1 = IR address.
- mdr_en  out  1  load MDR from memory data.
- load_a  out  1  load A from TOS.
- load_b  out  1  load B from TOS.
- alu_control  out  2  opcode[1:0] during ALU execute, else 00.
- push  out  1  stack push.
- pop  out  1  stack pop.
- stack_src  out  1  push data: 0 = ALU, 1 = MDR.
- depth  out  DEPTH_W  current stack occupancy.
- fault  out  1  sticky fault flag.
- fault_code  out  2  00 none, 01 underflow, 10 overflow, 11 memory timeout.

Behaviour:
Reset and strobes:
- Reset (asynchronous): state = FETCH, depth = 0, timer = 0, fault = 0, fault_code = 00.
- All strobes are 0 by default. They are asserted only in the states listed below.
- Reset asserted mid-instruction aborts it immediately; no strobe is asserted while reset is high.

States:
- FETCH: mem_read = 1, addr_src = 0. When mem_ready = 1, assert ir_write and pc_write (jump = 0) in that same cycle (Mealy), then go to DECODE. Otherwise stay.
- DECODE: no strobes. Runs the legality check, in this priority:
  - ALU ops 000–010 need depth >= 2.
  - NOT, POP and JZ need depth >= 1.
  - PUSH needs depth < STACK_DEPTH.
  - JMP has no requirement.
  - On failure go to FAULT with code 01 (underflow) or 10 (overflow).
  - Legal dispatch: ALU ops -> LOAD_A; PUSH -> MEM_RD; POP -> MEM_WR; JMP/JZ -> JUMP.
- LOAD_A: pop = 1, load_a = 1. NOT -> EXEC; otherwise -> LOAD_B.
- LOAD_B: pop = 1, load_b = 1, then -> EXEC.
- EXEC: push = 1, stack_src = 0, alu_control = opcode[1:0], then -> FETCH.
- MEM_RD: addr_src = 1, mem_read = 1. On mem_ready: mdr_en = 1 and go to PUSH_MDR.
- PUSH_MDR: push = 1, stack_src = 1, then -> FETCH.
- MEM_WR: addr_src = 1, mem_write = 1. On mem_ready: pop = 1 and go to FETCH.
- JUMP: jump = 1, pc_write = (opcode[0] ? tos_zero : 1), then -> FETCH. JZ does not pop.
- FAULT: all strobes 0. The state is absorbing; only reset leaves it. fault = 1 and fault_code hold.

Depth counter:
- depth increments on push and decrements on pop.
- push and pop are never asserted in the same cycle; an assertion must check this.
- Because DECODE validates first, depth never wraps in legal operation.

Timeout:
- The timer clears on entry to FETCH, MEM_RD and MEM_WR, and on every cycle with mem_ready = 1.
- It increments on each cycle in those states with mem_ready = 0.
- When it reaches WAIT_TIMEOUT, go to FAULT with code 11. No ir_write, mdr_en or pop is issued in that cycle.

Latency with zero wait states:
- ADD/SUB/AND: 5 cycles.
- NOT: 4 cycles.
- PUSH: 4 cycles.
- POP: 3 cycles.
- JMP/JZ: 3 cycles.
- Each wait cycle adds 1.

Decomposition:
- Package stack_ctrl_pkg holds:
  - opcode_e (3-bit enum of the eight opcodes);
  - state_e (FETCH, DECODE, LOAD_A, LOAD_B, EXEC, MEM_RD, PUSH_MDR, MEM_WR, JUMP, FAULT; 4-bit);
  - fault_e (2-bit);
  - constant ALU_PASS = 2'b00.
- One sub-module: stack_depth_tracker. It holds the depth counter plus the can_pop1, can_pop2 and can_push compare outputs, parametrised by STACK_DEPTH.

Test Plan:
1. Reset, then PUSH, PUSH, ADD with mem_ready always 1 -> depth goes 1, 2, then 1. alu_control = 00 in EXEC. Total 4 + 4 + 5 = 13 cycles.
2. Fetch with mem_ready low for 3 cycles -> mem_read is held 4 cycles; ir_write and pc_write pulse only in the 4th cycle.
3. POP with depth = 0, and separately SUB with depth = 1 -> FAULT, fault_code = 01, depth unchanged, no pop strobe.
4. STACK_DEPTH = 8: eight PUSHes succeed, the ninth -> FAULT with fault_code = 10, depth = 8, no mem_read after DECODE.
5. JZ with tos_zero = 0 -> pc_write = 0. JZ with tos_zero = 1 -> pc_write = 1 and jump = 1. depth unchanged in both cases.
6. mem_ready stuck low in MEM_WR -> FAULT, code 11, after exactly 15 wait cycles. Assert reset mid-FAULT -> all outputs 0, state FETCH.

Source files
------------

// File: rtl/stack_cpu_ctrl_v2_pkg.sv
// Shared types for the stack-machine controller: opcodes, FSM states, fault codes.
package stack_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_NOT  = 3'b011,
    OP_PUSH = 3'b100,
    OP_POP  = 3'b101,
    OP_JMP  = 3'b110,
    OP_JZ   = 3'b111
  } opcode_e;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    LOAD_A,
    LOAD_B,
    EXEC,
    MEM_RD,
    PUSH_MDR,
    MEM_WR,
    JUMP,
    FAULT
  } state_e;

  typedef enum logic [1:0] {
    FLT_NONE    = 2'b00,
    FLT_UNDER   = 2'b01,
    FLT_OVER    = 2'b10,
    FLT_TIMEOUT = 2'b11
  } fault_e;

  localparam logic [1:0] ALU_PASS = 2'b00;

  function automatic logic is_alu_op(input opcode_e op);
    return op inside {OP_ADD, OP_SUB, OP_AND};
  endfunction

endpackage

// File: rtl/stack_cpu_ctrl_v2_if.sv
// Controller <-> datapath/memory signal bundle; master is the controller side.
interface stack_cpu_ctrl_v2_if #(
  parameter  int unsigned STACK_DEPTH = 8,
  localparam int unsigned DEPTH_W     = $clog2(STACK_DEPTH + 1)
);

  logic [2:0]         opcode;
  logic               tos_zero;
  logic               mem_ready;
  logic               mem_read;
  logic               mem_write;
  logic               addr_src;
  logic               ir_write;
  logic               pc_write;
  logic               jump;
  logic               mdr_en;
  logic               load_a;
  logic               load_b;
  logic [1:0]         alu_control;
  logic               push;
  logic               pop;
  logic               stack_src;
  logic [DEPTH_W-1:0] depth;
  logic               fault;
  logic [1:0]         fault_code;

  modport master (
    input  opcode, tos_zero, mem_ready,
    output mem_read, mem_write, addr_src, ir_write, pc_write, jump, mdr_en,
           load_a, load_b, alu_control, push, pop, stack_src,
           depth, fault, fault_code
  );

  modport slave (
    output opcode, tos_zero, mem_ready,
    input  mem_read, mem_write, addr_src, ir_write, pc_write, jump, mdr_en,
           load_a, load_b, alu_control, push, pop, stack_src,
           depth, fault, fault_code
  );

endinterface

// File: rtl/stack_cpu_ctrl_v2_depth_tracker.sv
// Shadow occupancy counter of the hardware stack with legality compares for DECODE.
module stack_depth_tracker #(
  parameter  int unsigned STACK_DEPTH = 8,
  localparam int unsigned DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               push_i,
  input  logic               pop_i,
  output logic [DEPTH_W-1:0] depth_o,
  output logic               can_pop1_o,
  output logic               can_pop2_o,
  output logic               can_push_o
);

  logic [DEPTH_W-1:0] depth_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      depth_q <= '0;
    end else if (push_i) begin
      depth_q <= depth_q + 1'b1;
    end else if (pop_i) begin
      depth_q <= depth_q - 1'b1;
    end
  end

  assign depth_o    = depth_q;
  assign can_pop1_o = (depth_q >= DEPTH_W'(1));
  assign can_pop2_o = (depth_q >= DEPTH_W'(2));
  assign can_push_o = (depth_q <  DEPTH_W'(STACK_DEPTH));

  a_push_pop_excl: assert property (@(posedge clk_i) disable iff (rst_i) !(push_i && pop_i));

endmodule

// File: rtl/stack_cpu_ctrl_v2.sv
// Multicycle controller for the 3-bit-opcode stack machine with memory wait states,
// depth checking, memory timeout watchdog and a sticky FAULT state.
module stack_cpu_ctrl_v2
  import stack_ctrl_pkg::*;
#(
  parameter int unsigned STACK_DEPTH  = 8,
  parameter int unsigned WAIT_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                reset,
  stack_cpu_ctrl_v2_if.master bus
);

  localparam int unsigned DEPTH_W = $clog2(STACK_DEPTH + 1);
  localparam int unsigned TMR_W   = $clog2(WAIT_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(WAIT_TIMEOUT - 1);

  state_e             state_q;
  fault_e             fault_code_q;
  logic               fault_q;
  logic [TMR_W-1:0]   timer_q;

  opcode_e            op;
  fault_e             dec_fault;
  state_e             dispatch;
  logic               can_pop1, can_pop2, can_push;
  logic               mem_wait, timeout;
  logic               push_s, pop_s;
  logic [DEPTH_W-1:0] depth;

  assign op       = opcode_e'(bus.opcode);
  assign mem_wait = (state_q inside {FETCH, MEM_RD, MEM_WR}) && !bus.mem_ready;
  // Fires on the WAIT_TIMEOUT-th consecutive not-ready cycle; ready is low so no completion strobe leaks.
  assign timeout  = mem_wait && (timer_q == TMR_LAST);

  stack_depth_tracker #(
    .STACK_DEPTH (STACK_DEPTH)
  ) u_depth (
    .clk_i      (clk),
    .rst_i      (reset),
    .push_i     (push_s),
    .pop_i      (pop_s),
    .depth_o    (depth),
    .can_pop1_o (can_pop1),
    .can_pop2_o (can_pop2),
    .can_push_o (can_push)
  );

  always_comb begin
    dec_fault = FLT_NONE;
    if (is_alu_op(op) && !can_pop2) begin
      dec_fault = FLT_UNDER;
    end else if ((op inside {OP_NOT, OP_POP, OP_JZ}) && !can_pop1) begin
      dec_fault = FLT_UNDER;
    end else if ((op == OP_PUSH) && !can_push) begin
      dec_fault = FLT_OVER;
    end

    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_NOT: dispatch = LOAD_A;
      OP_PUSH:                        dispatch = MEM_RD;
      OP_POP:                         dispatch = MEM_WR;
      default:                        dispatch = JUMP;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= FETCH;
      fault_q      <= 1'b0;
      fault_code_q <= FLT_NONE;
      timer_q      <= '0;
    end else begin
      timer_q <= mem_wait ? timer_q + 1'b1 : '0;
      if (timeout) begin
        state_q      <= FAULT;
        fault_q      <= 1'b1;
        fault_code_q <= FLT_TIMEOUT;
      end else begin
        case (state_q)
          FETCH:    if (bus.mem_ready) state_q <= DECODE;
          DECODE: begin
            if (dec_fault != FLT_NONE) begin
              state_q      <= FAULT;
              fault_q      <= 1'b1;
              fault_code_q <= dec_fault;
            end else begin
              state_q <= dispatch;
            end
          end
          LOAD_A:   state_q <= (op == OP_NOT) ? EXEC : LOAD_B;
          LOAD_B:   state_q <= EXEC;
          EXEC:     state_q <= FETCH;
          MEM_RD:   if (bus.mem_ready) state_q <= PUSH_MDR;
          PUSH_MDR: state_q <= FETCH;
          MEM_WR:   if (bus.mem_ready) state_q <= FETCH;
          JUMP:     state_q <= FETCH;
          FAULT:    state_q <= FAULT;
          default:  state_q <= FETCH;
        endcase
      end
    end
  end

  // Strobes are Mealy on mem_ready/tos_zero and forced low while reset is held.
  always_comb begin
    bus.mem_read    = 1'b0;
    bus.mem_write   = 1'b0;
    bus.addr_src    = 1'b0;
    bus.ir_write    = 1'b0;
    bus.pc_write    = 1'b0;
    bus.jump        = 1'b0;
    bus.mdr_en      = 1'b0;
    bus.load_a      = 1'b0;
    bus.load_b      = 1'b0;
    bus.alu_control = ALU_PASS;
    bus.stack_src   = 1'b0;
    push_s          = 1'b0;
    pop_s           = 1'b0;
    if (!reset) begin
      case (state_q)
        FETCH: begin
          bus.mem_read = 1'b1;
          if (bus.mem_ready) begin
            bus.ir_write = 1'b1;
            bus.pc_write = 1'b1;
          end
        end
        LOAD_A: begin
          pop_s      = 1'b1;
          bus.load_a = 1'b1;
        end
        LOAD_B: begin
          pop_s      = 1'b1;
          bus.load_b = 1'b1;
        end
        EXEC: begin
          push_s          = 1'b1;
          bus.alu_control = bus.opcode[1:0];
        end
        MEM_RD: begin
          bus.addr_src = 1'b1;
          bus.mem_read = 1'b1;
          bus.mdr_en   = bus.mem_ready;
        end
        PUSH_MDR: begin
          push_s        = 1'b1;
          bus.stack_src = 1'b1;
        end
        MEM_WR: begin
          bus.addr_src  = 1'b1;
          bus.mem_write = 1'b1;
          pop_s         = bus.mem_ready;
        end
        JUMP: begin
          bus.jump     = 1'b1;
          bus.pc_write = bus.opcode[0] ? bus.tos_zero : 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.push       = push_s;
  assign bus.pop        = pop_s;
  assign bus.depth      = depth;
  assign bus.fault      = fault_q;
  assign bus.fault_code = fault_code_q;

endmodule

// File: tb/tb_stack_cpu_ctrl_v2.sv
// Directed bench for stack_cpu_ctrl_v2: cycle-by-cycle strobe, depth and fault checks.
module tb_stack_cpu_ctrl_v2;
  import stack_ctrl_pkg::*;

  // Strobe vector order: mem_read mem_write addr_src ir_write pc_write jump mdr_en load_a load_b alu[1:0] push pop stack_src
  localparam logic [13:0] S_IDLE  = 14'b0_0_0_0_0_0_0_0_0_00_0_0_0;
  localparam logic [13:0] S_FWAIT = 14'b1_0_0_0_0_0_0_0_0_00_0_0_0;
  localparam logic [13:0] S_FETCH = 14'b1_0_0_1_1_0_0_0_0_00_0_0_0;
  localparam logic [13:0] S_LDA   = 14'b0_0_0_0_0_0_0_1_0_00_0_1_0;
  localparam logic [13:0] S_LDB   = 14'b0_0_0_0_0_0_0_0_1_00_0_1_0;
  localparam logic [13:0] S_MRD   = 14'b1_0_1_0_0_0_1_0_0_00_0_0_0;
  localparam logic [13:0] S_MRDW  = 14'b1_0_1_0_0_0_0_0_0_00_0_0_0;
  localparam logic [13:0] S_PMDR  = 14'b0_0_0_0_0_0_0_0_0_00_1_0_1;
  localparam logic [13:0] S_MWR   = 14'b0_1_1_0_0_0_0_0_0_00_0_1_0;
  localparam logic [13:0] S_MWRW  = 14'b0_1_1_0_0_0_0_0_0_00_0_0_0;
  localparam logic [13:0] S_JMP   = 14'b0_0_0_0_1_1_0_0_0_00_0_0_0;
  localparam logic [13:0] S_JZ0   = 14'b0_0_0_0_0_1_0_0_0_00_0_0_0;
  localparam logic [13:0] S_EADD  = 14'b0_0_0_0_0_0_0_0_0_00_1_0_0;
  localparam logic [13:0] S_EAND  = 14'b0_0_0_0_0_0_0_0_0_10_1_0_0;
  localparam logic [13:0] S_ENOT  = 14'b0_0_0_0_0_0_0_0_0_11_1_0_0;

  logic clk;
  logic reset;
  int unsigned n_checks;
  int unsigned n_errors;
  logic [13:0] strb;

  stack_cpu_ctrl_v2_if #(.STACK_DEPTH(8)) bus ();

  stack_cpu_ctrl_v2 #(
    .STACK_DEPTH  (8),
    .WAIT_TIMEOUT (15)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign strb = {bus.mem_read, bus.mem_write, bus.addr_src, bus.ir_write, bus.pc_write,
                 bus.jump, bus.mdr_en, bus.load_a, bus.load_b, bus.alu_control,
                 bus.push, bus.pop, bus.stack_src};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs after the falling edge, then check before the next rising edge.
  task automatic step(input string tag, input logic [2:0] op, input logic rdy, input logic tz,
                      input logic [13:0] exp_s, input int unsigned exp_d);
    @(negedge clk);
    bus.opcode    = op;
    bus.mem_ready = rdy;
    bus.tos_zero  = tz;
    #1;
    chk({tag, ".strb"}, 32'(strb), 32'(exp_s));
    chk({tag, ".depth"}, 32'(bus.depth), exp_d);
  endtask

  task automatic chk_fault(input string tag, input logic f, input logic [1:0] code);
    chk({tag, ".fault"}, 32'(bus.fault), 32'(f));
    chk({tag, ".code"}, 32'(bus.fault_code), 32'(code));
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset         = 1'b1;
    bus.mem_ready = 1'b1;
    bus.opcode    = OP_PUSH;
    #1;
    chk({tag, ".strb"}, 32'(strb), 32'(S_IDLE));
    chk({tag, ".depth"}, 32'(bus.depth), 32'd0);
    chk_fault(tag, 1'b0, 2'b00);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic push_ok(input string tag, input int unsigned d);
    step({tag, ".F"}, OP_PUSH, 1'b1, 1'b0, S_FETCH, d);
    step({tag, ".D"}, OP_PUSH, 1'b1, 1'b0, S_IDLE,  d);
    step({tag, ".R"}, OP_PUSH, 1'b1, 1'b0, S_MRD,   d);
    step({tag, ".P"}, OP_PUSH, 1'b1, 1'b0, S_PMDR,  d);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    reset         = 1'b1;
    bus.opcode    = OP_ADD;
    bus.mem_ready = 1'b0;
    bus.tos_zero  = 1'b0;

    do_reset("rst0");

    // PUSH, PUSH, ADD with no wait states
    push_ok("push1", 0);
    push_ok("push2", 1);
    step("add.F", OP_ADD, 1'b1, 1'b0, S_FETCH, 2);
    step("add.D", OP_ADD, 1'b1, 1'b0, S_IDLE,  2);
    step("add.A", OP_ADD, 1'b1, 1'b0, S_LDA,   2);
    step("add.B", OP_ADD, 1'b1, 1'b0, S_LDB,   1);
    step("add.E", OP_ADD, 1'b1, 1'b0, S_EADD,  0);

    // JZ not taken, JZ taken, JMP
    step("jz0.F", OP_JZ, 1'b1, 1'b0, S_FETCH, 1);
    step("jz0.D", OP_JZ, 1'b1, 1'b0, S_IDLE,  1);
    step("jz0.J", OP_JZ, 1'b1, 1'b0, S_JZ0,   1);
    step("jz1.F", OP_JZ, 1'b1, 1'b1, S_FETCH, 1);
    step("jz1.D", OP_JZ, 1'b1, 1'b1, S_IDLE,  1);
    step("jz1.J", OP_JZ, 1'b1, 1'b1, S_JMP,   1);
    step("jmp.F", OP_JMP, 1'b1, 1'b0, S_FETCH, 1);
    step("jmp.D", OP_JMP, 1'b1, 1'b0, S_IDLE,  1);
    step("jmp.J", OP_JMP, 1'b1, 1'b0, S_JMP,   1);

    // POP, PUSH with two read wait states, PUSH, AND, NOT
    step("pop.F", OP_POP, 1'b1, 1'b0, S_FETCH, 1);
    step("pop.D", OP_POP, 1'b1, 1'b0, S_IDLE,  1);
    step("pop.W", OP_POP, 1'b1, 1'b0, S_MWR,   1);
    step("pw.F",  OP_PUSH, 1'b1, 1'b0, S_FETCH, 0);
    step("pw.D",  OP_PUSH, 1'b1, 1'b0, S_IDLE,  0);
    step("pw.R0", OP_PUSH, 1'b0, 1'b0, S_MRDW,  0);
    step("pw.R1", OP_PUSH, 1'b0, 1'b0, S_MRDW,  0);
    step("pw.R2", OP_PUSH, 1'b1, 1'b0, S_MRD,   0);
    step("pw.P",  OP_PUSH, 1'b1, 1'b0, S_PMDR,  0);
    push_ok("push3", 1);
    step("and.F", OP_AND, 1'b1, 1'b0, S_FETCH, 2);
    step("and.D", OP_AND, 1'b1, 1'b0, S_IDLE,  2);
    step("and.A", OP_AND, 1'b1, 1'b0, S_LDA,   2);
    step("and.B", OP_AND, 1'b1, 1'b0, S_LDB,   1);
    step("and.E", OP_AND, 1'b1, 1'b0, S_EAND,  0);
    step("not.F", OP_NOT, 1'b1, 1'b0, S_FETCH, 1);
    step("not.D", OP_NOT, 1'b1, 1'b0, S_IDLE,  1);
    step("not.A", OP_NOT, 1'b1, 1'b0, S_LDA,   1);
    step("not.E", OP_NOT, 1'b1, 1'b0, S_ENOT,  0);

    // SUB with depth 1 -> underflow fault, absorbing
    step("sub.F",  OP_SUB, 1'b1, 1'b0, S_FETCH, 1);
    chk_fault("sub.F", 1'b0, 2'b00);
    step("sub.D",  OP_SUB, 1'b1, 1'b0, S_IDLE,  1);
    step("sub.X0", OP_SUB, 1'b1, 1'b0, S_IDLE,  1);
    chk_fault("sub.X0", 1'b1, 2'b01);
    step("sub.X1", OP_PUSH, 1'b1, 1'b0, S_IDLE, 1);
    chk_fault("sub.X1", 1'b1, 2'b01);

    // Fetch with three wait states, then POP at depth 0 -> underflow
    do_reset("rst1");
    step("fw.0", OP_POP, 1'b0, 1'b0, S_FWAIT, 0);
    step("fw.1", OP_POP, 1'b0, 1'b0, S_FWAIT, 0);
    step("fw.2", OP_POP, 1'b0, 1'b0, S_FWAIT, 0);
    step("fw.3", OP_POP, 1'b1, 1'b0, S_FETCH, 0);
    step("pop0.D", OP_POP, 1'b1, 1'b0, S_IDLE, 0);
    step("pop0.X", OP_POP, 1'b1, 1'b0, S_IDLE, 0);
    chk_fault("pop0.X", 1'b1, 2'b01);

    // Fill the stack, ninth PUSH overflows
    do_reset("rst2");
    for (int i = 0; i < 8; i++) begin
      push_ok($sformatf("fill%0d", i), i);
    end
    step("ovf.F", OP_PUSH, 1'b1, 1'b0, S_FETCH, 8);
    step("ovf.D", OP_PUSH, 1'b1, 1'b0, S_IDLE,  8);
    step("ovf.X", OP_PUSH, 1'b1, 1'b0, S_IDLE,  8);
    chk_fault("ovf.X", 1'b1, 2'b10);

    // 14 fetch waits are tolerated; 15 write waits time out
    do_reset("rst3");
    push_ok("push4", 0);
    for (int i = 0; i < 14; i++) begin
      step($sformatf("tf.%0d", i), OP_POP, 1'b0, 1'b0, S_FWAIT, 1);
    end
    step("tf.R", OP_POP, 1'b1, 1'b0, S_FETCH, 1);
    chk_fault("tf.R", 1'b0, 2'b00);
    step("to.D", OP_POP, 1'b1, 1'b0, S_IDLE, 1);
    for (int i = 0; i < 15; i++) begin
      step($sformatf("to.W%0d", i), OP_POP, 1'b0, 1'b0, S_MWRW, 1);
    end
    step("to.X", OP_POP, 1'b0, 1'b0, S_IDLE, 1);
    chk_fault("to.X", 1'b1, 2'b11);
    step("to.X1", OP_POP, 1'b1, 1'b0, S_IDLE, 1);
    chk_fault("to.X1", 1'b1, 2'b11);

    // Reset out of FAULT returns to FETCH
    do_reset("rst4");
    step("post.F", OP_PUSH, 1'b1, 1'b0, S_FETCH, 0);
    chk_fault("post.F", 1'b0, 2'b00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
